// File: rtl/ctrl_unit_if.sv
// Bus between the multicycle control unit and the accumulator datapath
// (instruction memory, ALU flags, register file and accumulator controls).
interface ctrl_unit_if;
    logic [7:0] instr;
    logic       z_in;
    logic       c_in;
    logic [7:0] pc;
    logic [3:0] alu_sel;
    logic       accum_ld;
    logic [1:0] accum_src;
    logic [7:0] opnd;
    logic [3:0] rf_addr;
    logic       rf_we;
    logic       z_flag;
    logic       c_flag;
    logic       halted;
    logic       illegal;

    modport master (
        input  instr, z_in, c_in,
        output pc, alu_sel, accum_ld, accum_src, opnd, rf_addr, rf_we,
               z_flag, c_flag, halted, illegal
    );

    modport slave (
        output instr, z_in, c_in,
        input  pc, alu_sel, accum_ld, accum_src, opnd, rf_addr, rf_we,
               z_flag, c_flag, halted, illegal
    );
endinterface

// File: rtl/ctrl_unit.sv
// Multicycle fetch/decode/execute controller for the 8-bit accumulator CPU.
// Optional macro CTRL_ILLEGAL_TRAP_EN: reserved opcodes trap to HALT and set the sticky illegal flag.
module ctrl_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_unit_if.master  bus
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_MOVR = 4'b0100;
    localparam logic [3:0] OP_MOVA = 4'b0101;
    localparam logic [3:0] OP_LDI  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_JZ   = 4'b1000;
    localparam logic [3:0] OP_JC   = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_RF  = 2'b01;
    localparam logic [1:0] SRC_OPD = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPER   = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    function automatic logic is_two_byte(input logic [3:0] op);
        case (op)
            OP_LDI, OP_JMP, OP_JZ, OP_JC: is_two_byte = 1'b1;
            default:                      is_two_byte = 1'b0;
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: is_alu_op = 1'b1;
            default:                                is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_reserved(input logic [3:0] op);
        case (op)
            4'b1010, 4'b1101, 4'b1110: is_reserved = 1'b1;
            default:                   is_reserved = 1'b0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opnd_q, opnd_d;
    logic [7:0] pc_q, pc_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       illegal_q, illegal_d;
    logic       halted_q, halted_d;

    logic [3:0] op_s;
    logic [3:0] alu_sel_s;
    logic       accum_ld_s;
    logic [1:0] accum_src_s;
    logic       rf_we_s;

    assign op_s = ir_q[7:4];

    // Next-state logic: sequencing, pc/ir/operand updates and flag capture
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        opnd_d    = opnd_q;
        pc_d      = pc_q;
        z_d       = z_q;
        c_d       = c_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = bus.instr;
                pc_d    = pc_q + 8'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_two_byte(op_s)) begin
                    state_d = S_OPER;
                end else if (op_s == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_reserved(op_s)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d   = S_EXEC;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_OPER: begin
                opnd_d  = bus.instr;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_alu_op(op_s)) begin
                    z_d = bus.z_in;
                    c_d = bus.c_in;
                end else begin
                    z_d = z_q;
                    c_d = c_q;
                end
                // Jumps test the flags as they stood before this EXEC cycle
                case (op_s)
                    OP_JMP:  pc_d = opnd_q;
                    OP_JZ:   pc_d = z_q ? opnd_q : pc_q;
                    OP_JC:   pc_d = c_q ? opnd_q : pc_q;
                    default: pc_d = pc_q;
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        halted_d = (state_d == S_HALT);
    end

    // Architectural state register with dominant synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= 8'h00;
            opnd_q    <= 8'h00;
            pc_q      <= RESET_PC;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            opnd_q    <= opnd_d;
            pc_q      <= pc_d;
            z_q       <= z_d;
            c_q       <= c_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    // EXEC-cycle strobes decoded from state and ir; reset suppresses them in its own cycle
    always_comb begin
        alu_sel_s   = 4'b0000;
        accum_ld_s  = 1'b0;
        accum_src_s = SRC_ALU;
        rf_we_s     = 1'b0;
        if ((state_q == S_EXEC) && !rst) begin
            case (op_s)
                OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
                    alu_sel_s   = op_s;
                    accum_src_s = SRC_ALU;
                    accum_ld_s  = 1'b1;
                end
                OP_MOVR: begin
                    accum_src_s = SRC_RF;
                    accum_ld_s  = 1'b1;
                end
                OP_MOVA: begin
                    rf_we_s = 1'b1;
                end
                OP_LDI: begin
                    accum_src_s = SRC_OPD;
                    accum_ld_s  = 1'b1;
                end
                OP_NOP: begin
                    accum_ld_s = 1'b0;
                end
                default: begin
                    accum_ld_s = 1'b0;
                end
            endcase
        end else begin
            alu_sel_s   = 4'b0000;
            accum_ld_s  = 1'b0;
            accum_src_s = SRC_ALU;
            rf_we_s     = 1'b0;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.opnd      = opnd_q;
    assign bus.rf_addr   = ir_q[3:0];
    assign bus.z_flag    = z_q;
    assign bus.c_flag    = c_q;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;
    assign bus.alu_sel   = alu_sel_s;
    assign bus.accum_ld  = accum_ld_s;
    assign bus.accum_src = accum_src_s;
    assign bus.rf_we     = rf_we_s;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: small program images, an ALU/accumulator/register-file model,
// and cycle-exact checks of strobes, pc and flags.
module tb_ctrl_unit;

    logic       clk;
    logic       rst;
    logic [7:0] mem [0:255];
    logic [7:0] rf  [0:15];
    logic [7:0] acc;
    logic [8:0] alu_res;
    int         total;
    int         bad;

    ctrl_unit_if bus ();

    ctrl_unit #(.RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.instr = mem[bus.pc];
    assign bus.z_in  = (alu_res[7:0] == 8'h00);
    assign bus.c_in  = alu_res[8];

    // Reference ALU
    always_comb begin
        alu_res = 9'h000;
        case (bus.alu_sel)
            4'b0001: alu_res = {1'b0, acc} + {1'b0, rf[bus.rf_addr]};
            4'b0010: alu_res = {1'b0, acc} - {1'b0, rf[bus.rf_addr]};
            4'b0011: alu_res = {1'b0, ~(acc | rf[bus.rf_addr])};
            4'b1011: alu_res = {acc, 1'b0};
            4'b1100: alu_res = {acc[0], 1'b0, acc[7:1]};
            default: alu_res = 9'h000;
        endcase
    end

    // Accumulator and register-file model driven by the strobes
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
            rf[1] <= 8'hFB;
        end else begin
            if (bus.accum_ld) begin
                case (bus.accum_src)
                    2'b00:   acc <= alu_res[7:0];
                    2'b01:   acc <= rf[bus.rf_addr];
                    2'b10:   acc <= bus.opnd;
                    default: acc <= 8'hXX;
                endcase
            end
            if (bus.rf_we) rf[bus.rf_addr] <= acc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench at cycle 1 (first FETCH) with rst released
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.halted && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.halted}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ld;
        int second_ld;
        int strobe_seen;
        total = 0;
        bad   = 0;
        rst   = 1'b1;

        // Reset, LDI/ADD latency, taken JZ and JC, HALT freeze
        fill_mem();
        mem[8'h00] = 8'h60; mem[8'h01] = 8'h05; mem[8'h02] = 8'h11;
        mem[8'h03] = 8'h80; mem[8'h04] = 8'h40;
        mem[8'h40] = 8'h90; mem[8'h41] = 8'h50;
        rst = 1'b1;
        tick();
        tick();
        check("rst_pc",       {24'd0, bus.pc}, 32'h00);
        check("rst_halted",   {31'd0, bus.halted}, 32'd0);
        check("rst_zflag",    {31'd0, bus.z_flag}, 32'd0);
        check("rst_cflag",    {31'd0, bus.c_flag}, 32'd0);
        check("rst_illegal",  {31'd0, bus.illegal}, 32'd0);
        check("rst_strobes",  {28'd0, bus.accum_ld, bus.rf_we, bus.accum_src}, 32'd0);
        check("rst_alu_sel",  {28'd0, bus.alu_sel}, 32'd0);
        rst = 1'b0;
        first_ld  = -1;
        second_ld = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 1) check("first_fetch_pc", {24'd0, bus.pc}, 32'h00);
            if (bus.accum_ld) begin
                if (first_ld < 0) first_ld = cyc;
                else if (second_ld < 0) second_ld = cyc;
            end
            if (cyc == 7) check("add_alu_sel", {28'd0, bus.alu_sel}, 32'h1);
            if (cyc == 8) begin
                check("add_acc",   {24'd0, acc}, 32'h00);
                check("add_zflag", {31'd0, bus.z_flag}, 32'd1);
                check("add_cflag", {31'd0, bus.c_flag}, 32'd1);
            end
            if (cyc == 12) check("jz_taken_pc", {24'd0, bus.pc}, 32'h40);
            if (cyc < 12) tick();
        end
        check("ldi_ld_cycle", first_ld, 32'd4);
        check("add_ld_cycle", second_ld, 32'd7);
        run_to_halt("jc_taken_halt", 40);
        check("jc_taken_pc", {24'd0, bus.pc}, 32'h51);
        strobe_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.accum_ld || bus.rf_we || !bus.halted) strobe_seen = 1;
        end
        check("halt_freeze_pc", {24'd0, bus.pc}, 32'h51);
        check("halt_quiet", strobe_seen, 32'd0);

        // Not-taken JZ and JC with both flags clear
        fill_mem();
        mem[8'h00] = 8'h70; mem[8'h01] = 8'h10;
        mem[8'h10] = 8'h80; mem[8'h11] = 8'h40;
        mem[8'h12] = 8'h90; mem[8'h13] = 8'h40;
        do_reset();
        ticks(8);
        check("jz_not_taken_pc", {24'd0, bus.pc}, 32'h12);
        run_to_halt("jc_nt_halt", 40);
        check("jc_not_taken_pc", {24'd0, bus.pc}, 32'h15);

        // NOP at FF wraps pc to 00
        fill_mem();
        mem[8'h00] = 8'h70; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h00;
        do_reset();
        ticks(5);
        check("wrap_fetch_pc", {24'd0, bus.pc}, 32'h00);

        // JMP at FE: operand fetch wraps to 00, then jump lands on operand
        fill_mem();
        mem[8'h00] = 8'h70; mem[8'h01] = 8'hFE;
        mem[8'hFE] = 8'h70; mem[8'hFF] = 8'h20;
        do_reset();
        ticks(7);
        check("wrap_oper_pc", {24'd0, bus.pc}, 32'h00);
        tick();
        check("wrap_jmp_pc", {24'd0, bus.pc}, 32'h20);
        run_to_halt("wrap_halt", 20);
        check("wrap_halt_pc", {24'd0, bus.pc}, 32'h21);

        // Reserved opcode D0
        fill_mem();
        mem[8'h00] = 8'hD0;
        do_reset();
        ticks(3);
        check("rsv_pc", {24'd0, bus.pc}, 32'h01);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("rsv_halted",  {31'd0, bus.halted}, 32'd1);
        check("rsv_illegal", {31'd0, bus.illegal}, 32'd1);
        ticks(5);
        check("rsv_sticky",  {31'd0, bus.illegal}, 32'd1);
`else
        check("rsv_halted",  {31'd0, bus.halted}, 32'd0);
        check("rsv_illegal", {31'd0, bus.illegal}, 32'd0);
        run_to_halt("rsv_nop_halt", 20);
        check("rsv_nop_pc",  {24'd0, bus.pc}, 32'h02);
`endif

        // MOVA / MOVR / SUB with borrow
        fill_mem();
        mem[8'h00] = 8'h60; mem[8'h01] = 8'h3C; mem[8'h02] = 8'h52;
        mem[8'h03] = 8'h60; mem[8'h04] = 8'h00; mem[8'h05] = 8'h42;
        mem[8'h06] = 8'h21;
        do_reset();
        ticks(13);
        check("ldi0_zflag_held", {31'd0, bus.z_flag}, 32'd0);
        run_to_halt("mov_halt", 60);
        check("mova_rf2",  {24'd0, rf[2]}, 32'h3C);
        check("sub_acc",   {24'd0, acc}, 32'h41);
        check("sub_zflag", {31'd0, bus.z_flag}, 32'd0);
        check("sub_cflag", {31'd0, bus.c_flag}, 32'd1);

        // Reset during the EXEC cycle of ADD suppresses the load
        fill_mem();
        mem[8'h00] = 8'h60; mem[8'h01] = 8'h05; mem[8'h02] = 8'h11;
        do_reset();
        ticks(6);
        check("mid_exec_ld_before", {31'd0, bus.accum_ld}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_exec_ld_gated", {31'd0, bus.accum_ld}, 32'd0);
        check("mid_exec_sel_gated", {28'd0, bus.alu_sel}, 32'd0);
        tick();
        check("mid_exec_acc", {24'd0, acc}, 32'h05);
        check("mid_exec_pc",  {24'd0, bus.pc}, 32'h00);
        rst = 1'b0;
        tick();
        check("mid_exec_refetch_pc", {24'd0, bus.pc}, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
